// File: rtl/ov7670_frame_ctrl.sv
// Frame-level sequencer for the OV7670 capture path (pclk_24 domain).
// Grants one whole frame per request, checks geometry, ping-pongs two framebuffers.
module ov7670_frame_ctrl #(
   parameter int LINES          = 144,
   parameter int BYTES_PER_LINE = 176,
   parameter int TO_W           = 22
) (
   input  logic       pclk_24,
   input  logic       reset_n,
   input  logic       cfg_done,
   input  logic       cap_req,
   input  logic       continuous,
   input  logic       vsync,
   input  logic       href,
   input  logic [1:0] buf_release,
   output logic       capture_en,
   output logic       buf_sel,
   output logic [1:0] buf_full,
   output logic       frame_done,
   output logic       frame_err,
   output logic [7:0] line_cnt,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_CAPTURE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state, state_nxt;
   logic              vsync_q, href_q;
   logic              pending;
   logic              err, err_nxt;
   logic [8:0]        byte_cnt;
   logic [7:0]        line_nxt;
   logic [TO_W-1:0]   wdog;
   logic              vs_fall, vs_rise, hr_fall;
   logic              abort;

   assign vs_fall = vsync_q & ~vsync;
   assign vs_rise = ~vsync_q & vsync;
   assign hr_fall = href_q & ~href;
   assign busy    = (state == S_ARM) || (state == S_CAPTURE);
   assign abort   = ~cfg_done || (wdog == '1);

   // Line accounting is resolved before the vs_rise decision so a line
   // ending in the same cycle as the frame still counts.
   always_comb begin
      line_nxt = line_cnt;
      err_nxt  = err;
      if (hr_fall) begin
         if (byte_cnt != 9'(BYTES_PER_LINE))
            err_nxt = 1'b1;
         if (line_cnt != 8'hFF)
            line_nxt = line_cnt + 8'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (cfg_done && (pending || continuous) && !buf_full[buf_sel])
               state_nxt = S_ARM;
         S_ARM:
            if (abort)
               state_nxt = S_ERROR;
            else if (vs_fall)
               state_nxt = S_CAPTURE;
         S_CAPTURE:
            if (abort)
               state_nxt = S_ERROR;
            else if (vs_rise)
               state_nxt = (!err_nxt && line_nxt == 8'(LINES)) ? S_DONE : S_ERROR;
         S_DONE:  state_nxt = S_IDLE;
         S_ERROR: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk_24 or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         pending    <= 1'b0;
         err        <= 1'b0;
         byte_cnt   <= '0;
         line_cnt   <= '0;
         wdog       <= '0;
         capture_en <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         buf_sel    <= 1'b0;
         buf_full   <= '0;
      end else begin
         state      <= state_nxt;
         vsync_q    <= vsync;
         href_q     <= href;
         pending    <= cap_req | (pending & ~(state_nxt == S_ARM && state != S_ARM));
         capture_en <= (state_nxt == S_CAPTURE);
         frame_done <= (state_nxt == S_DONE);
         frame_err  <= (state_nxt == S_ERROR);

         if (state_nxt != state)
            wdog <= '0;
         else if (busy)
            wdog <= wdog + 1'b1;

         if (state == S_ARM) begin
            byte_cnt <= '0;
            line_cnt <= '0;
            err      <= 1'b0;
         end else if (state == S_CAPTURE) begin
            err      <= err_nxt;
            line_cnt <= line_nxt;
            if (hr_fall)
               byte_cnt <= '0;
            else if (href && byte_cnt != '1)
               byte_cnt <= byte_cnt + 9'd1;
         end

         for (int unsigned i = 0; i < 2; i++) begin
            if (state == S_DONE && buf_sel == i[0])
               buf_full[i] <= 1'b1;
            else if (buf_release[i])
               buf_full[i] <= 1'b0;
         end
         if (state == S_DONE)
            buf_sel <= ~buf_sel;
      end
   end

endmodule
